valu_pipe: RTL and testbench
============================

// Module: valu_pipe
// PURPOSE
//  Registered, handshaked successor of the combinational vector ALU. Executes the
//  existing 16 lane-wise ops on DATA_WIDTH-bit operands with lane width from the ww field.
//  Single-cycle ops complete in 1 clock; multiplies take a MUL_CYCLES multi-cycle path.
//  Sits between EX operand mux and WB; valid/ready on both sides for stall propagation.
// PARAMETERS
//  DATA_WIDTH  64  operand/result width; multiple of 32, >=64
//  MUL_CYCLES  3   cycles spent in MUL state for vmule/vmulo (>=1)
//  RD_WIDTH    5   destination register tag width
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           async active-low reset
//  in_vld        in   1           operation valid
//  in_rdy        out  1           block can accept operation
//  ra, rb        in   DATA_WIDTH  source operands, bit 0 = MSB
//  alu_ctrl      in   14          {opcode[0:5], ww[0:1], func[0:5]}
//  imme          in   5           shift immediate
//  in_regwrite   in   1           writeback request from decode
//  in_rd         in   RD_WIDTH    destination register
//  out_vld       out  1           result valid
//  out_rdy       in   1           WB accepts result
//  alu_out       out  DATA_WIDTH  result
//  out_regwrite  out  1           qualified writeback enable
//  out_rd        out  RD_WIDTH    destination register, carried with result
//  busy          out  1           FSM not IDLE or out_vld high
// BEHAVIOUR
//  Reset: state=IDLE, mul counter=0, out_vld=0, alu_out=0, out_regwrite=0, out_rd=0.
//  Funcs: 00 and,01 or,02 xor,03 not ra,04 mov ra,05 vadd,06 vsub,07 vmule,08 vmulo,
//   09 rotate-by-half,0A sll rb,0B sll imm,0C srl rb,0D srl imm,0E sra rb,0F sra imm.
//  ww: 00=8b,01=16b,10=32b,11=DATA_WIDTH lanes; add/sub wrap per lane, no carry across.
//  Shift amount = low log2(lane) bits of rb's own lane LSBs, or imme[low bits]; imm shift
//   at ww=11 limited to imme (0..31).
//  Multiply: even/odd lanes of width L produce 2L products; ww=11 invalid.
//  Handshake: accept when in_vld&&in_rdy. in_rdy = (state==IDLE)&&(!out_vld||out_rdy).
//   Output fields stable while out_vld&&!out_rdy. Output slot cleared when out_rdy
//   and no new result loads.
//  FSM IDLE: accept non-mul -> result registered next edge, out_vld=1 (latency 1).
//   Accept mul -> latch ra,rb,ww,rd,regwrite; goto MUL, counter=0.
//  MUL: counter++ each cycle; at counter==MUL_CYCLES-1 goto DONE. in_rdy=0.
//  DONE: load product when !out_vld||out_rdy, goto IDLE; else wait in DONE.
//   Latency mul = MUL_CYCLES+1 with no backpressure.
//  Invalid func, or mul with ww=11: out_vld=1, alu_out=0, out_regwrite=0 (1 cycle).
//  out_regwrite = in_regwrite && func valid && ww valid, captured at accept.
//  Back-to-back: with out_rdy=1, one non-mul op per cycle throughput.
//  Simultaneous drain+load of output slot: new result wins, out_vld stays 1.
//  rst_n low mid-MUL: abort, all state to reset values; latched operands discarded.
// CONFIGURATION
//  VALU_SAT_EN defined: funcs 0x10 vadds, 0x11 vsubs = unsigned saturating per lane
//   (clamp to all-ones / zero), valid for all ww, latency 1.
//  VALU_SAT_EN undefined: 0x10/0x11 are invalid funcs (zero result, out_regwrite=0).
// TESTING
//  Reset mid-op: drive rst_n=0 in MUL -> next cycle out_vld=0, in_rdy=1 after release.
//  vadd ww=00 ra=0xFF01..., rb=0x0101... -> next cycle lane0=0x00, lane1=0x02, no carry;
//   out_regwrite=1 with in_regwrite=1.
//  vmule ww=01 ra lane0=0xFFFF, rb lane0=0x0002 -> after MUL_CYCLES+1, alu_out[0:31]
//   =0x0001FFFE; in_rdy=0 throughout MUL.
//  vmulo ww=11 -> 1 cycle later alu_out=0, out_vld=1, out_regwrite=0.
//  Backpressure: out_rdy=0 for 4 cycles after sll ww=10 ra=1, rb=0x...1F -> out holds
//   0x80000000 per lane, in_rdy=0; release -> 1-cycle accept of next op.
//  VALU_SAT_EN: vadds ww=00 0xF0+0x20 -> 0xFF; without macro -> out_regwrite=0, out=0.

Source files
------------

// File: rtl/valu_pipe.sv
// Registered, valid/ready vector ALU: 1-cycle lane-wise ops plus a multi-cycle multiply path.
// Optional VALU_SAT_EN adds unsigned saturating vadds (0x10) / vsubs (0x11).

// Whole-vector result for one fixed lane width; lanes are indexed from the LSB here.
module valu_lanes #(
  parameter int DW = 64,
  parameter int LW = 8
) (
  input  logic [5:0]    func,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [4:0]    imme,
  output logic [DW-1:0] res
);
  localparam int N  = DW / LW;
  localparam int SW = $clog2(LW);

  logic [DW-1:0] lane_res;
  logic [DW-1:0] mul_res;
  logic [LW-1:0] la, lb, lr;
  logic [SW-1:0] shr, shi;

  always_comb begin
    lane_res = '0;
    la = '0;
    lb = '0;
    lr = '0;
    shr = '0;
    shi = '0;
    for (int i = 0; i < N; i++) begin
      la  = a[i*LW +: LW];
      lb  = b[i*LW +: LW];
      shr = SW'(lb);
      shi = SW'(imme);
      case (func)
        6'h00: lr = la & lb;
        6'h01: lr = la | lb;
        6'h02: lr = la ^ lb;
        6'h03: lr = ~la;
        6'h04: lr = la;
        6'h05: lr = la + lb;
        6'h06: lr = la - lb;
        6'h09: lr = {la[LW/2-1:0], la[LW-1:LW/2]};
        6'h0A: lr = la << shr;
        6'h0B: lr = la << shi;
        6'h0C: lr = la >> shr;
        6'h0D: lr = la >> shi;
        6'h0E: lr = LW'($signed(la) >>> shr);
        6'h0F: lr = LW'($signed(la) >>> shi);
`ifdef VALU_SAT_EN
        6'h10: lr = (la + lb < la) ? '1 : la + lb;
        6'h11: lr = (lb > la) ? '0 : la - lb;
`endif
        default: lr = '0;
      endcase
      lane_res[i*LW +: LW] = lr;
    end
  end

  // Product slot k pairs lanes 2k+1 (even in MSB-first numbering) and 2k (odd).
  if (2 * LW <= DW) begin : g_mul
    always_comb begin
      mul_res = '0;
      for (int k = 0; k < N / 2; k++) begin
        if (func == 6'h07)
          mul_res[k*2*LW +: 2*LW] = {{LW{1'b0}}, a[(2*k+1)*LW +: LW]} * {{LW{1'b0}}, b[(2*k+1)*LW +: LW]};
        else
          mul_res[k*2*LW +: 2*LW] = {{LW{1'b0}}, a[2*k*LW +: LW]} * {{LW{1'b0}}, b[2*k*LW +: LW]};
      end
    end
  end else begin : g_nomul
    assign mul_res = '0;
  end

  assign res = (func == 6'h07 || func == 6'h08) ? mul_res : lane_res;
endmodule

// state | meaning
// IDLE  | accepting ops; non-mul results load the output slot directly
// MUL   | multiply in flight on latched operands, counting MUL_CYCLES
// DONE  | product ready, waiting for the output slot to free up
module valu_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int MUL_CYCLES = 3,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rb,
  input  logic [13:0]           alu_ctrl,
  input  logic [4:0]            imme,
  input  logic                  in_regwrite,
  input  logic [RD_WIDTH-1:0]   in_rd,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  out_regwrite,
  output logic [RD_WIDTH-1:0]   out_rd,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]            ww_q, ww_d;
  logic                  odd_q, odd_d;
  logic [RD_WIDTH-1:0]   rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] alu_out_q, alu_out_d;
  logic                  out_regwrite_q, out_regwrite_d;
  logic [RD_WIDTH-1:0]   out_rd_q, out_rd_d;

  logic [5:0]            func_in, op_func;
  logic [1:0]            ww_in, op_ww;
  logic                  is_mul_in, func_ok, op_ok, slot_free, accept;
  logic [DATA_WIDTH-1:0] op_a, op_b, res, res8, res16, res32, resw;
  logic                  unused_opcode;

  assign func_in       = alu_ctrl[5:0];
  assign ww_in         = alu_ctrl[7:6];
  assign unused_opcode = ^alu_ctrl[13:8];
  assign is_mul_in     = (func_in == 6'h07) || (func_in == 6'h08);
`ifdef VALU_SAT_EN
  assign func_ok = (func_in <= 6'h11);
`else
  assign func_ok = (func_in <= 6'h0F);
`endif
  assign op_ok     = func_ok && !(is_mul_in && ww_in == 2'b11);
  assign slot_free = !out_vld_q || out_rdy;
  assign in_rdy    = (state_q == IDLE) && slot_free;
  assign accept    = in_vld && in_rdy;

  // One shared datapath: live operands in IDLE, latched multiply operands otherwise.
  assign op_a    = (state_q == IDLE) ? ra : a_q;
  assign op_b    = (state_q == IDLE) ? rb : b_q;
  assign op_ww   = (state_q == IDLE) ? ww_in : ww_q;
  assign op_func = (state_q == IDLE) ? func_in : (odd_q ? 6'h08 : 6'h07);

  valu_lanes #(.DW(DATA_WIDTH), .LW(8))  u_l8  (.func(op_func), .a(op_a), .b(op_b), .imme(imme), .res(res8));
  valu_lanes #(.DW(DATA_WIDTH), .LW(16)) u_l16 (.func(op_func), .a(op_a), .b(op_b), .imme(imme), .res(res16));
  valu_lanes #(.DW(DATA_WIDTH), .LW(32)) u_l32 (.func(op_func), .a(op_a), .b(op_b), .imme(imme), .res(res32));
  valu_lanes #(.DW(DATA_WIDTH), .LW(DATA_WIDTH)) u_lw (.func(op_func), .a(op_a), .b(op_b), .imme(imme), .res(resw));

  always_comb begin
    case (op_ww)
      2'b00:   res = res8;
      2'b01:   res = res16;
      2'b10:   res = res32;
      default: res = resw;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    ww_d           = ww_q;
    odd_d          = odd_q;
    rd_d           = rd_q;
    rw_d           = rw_q;
    out_vld_d      = out_vld_q;
    alu_out_d      = alu_out_q;
    out_regwrite_d = out_regwrite_q;
    out_rd_d       = out_rd_q;
    if (out_rdy) begin
      out_vld_d      = 1'b0;
      alu_out_d      = '0;
      out_regwrite_d = 1'b0;
      out_rd_d       = '0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_ok && is_mul_in) begin
            a_d     = ra;
            b_d     = rb;
            ww_d    = ww_in;
            odd_d   = func_in[3];
            rd_d    = in_rd;
            rw_d    = in_regwrite;
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            out_vld_d      = 1'b1;
            alu_out_d      = op_ok ? res : '0;
            out_regwrite_d = in_regwrite && op_ok;
            out_rd_d       = in_rd;
          end
        end
      end
      MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        if (slot_free) begin
          out_vld_d      = 1'b1;
          alu_out_d      = res;
          out_regwrite_d = rw_q;
          out_rd_d       = rd_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      ww_q           <= '0;
      odd_q          <= 1'b0;
      rd_q           <= '0;
      rw_q           <= 1'b0;
      out_vld_q      <= 1'b0;
      alu_out_q      <= '0;
      out_regwrite_q <= 1'b0;
      out_rd_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      ww_q           <= ww_d;
      odd_q          <= odd_d;
      rd_q           <= rd_d;
      rw_q           <= rw_d;
      out_vld_q      <= out_vld_d;
      alu_out_q      <= alu_out_d;
      out_regwrite_q <= out_regwrite_d;
      out_rd_q       <= out_rd_d;
    end
  end

  assign out_vld      = out_vld_q;
  assign alu_out      = alu_out_q;
  assign out_regwrite = out_regwrite_q;
  assign out_rd       = out_rd_q;
  assign busy         = (state_q != IDLE) || out_vld_q;
endmodule

// File: tb/tb_valu_pipe.sv
// Scoreboard bench for valu_pipe: directed cases with hand-derived results, then random
// traffic checked against a lane-by-lane reference model, with random output backpressure.
module tb_valu_pipe;
  localparam int DW = 64;
  localparam int MC = 3;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld, in_rdy, in_regwrite, out_vld, out_rdy, out_regwrite, busy;
  logic [DW-1:0] ra, rb, alu_out;
  logic [13:0]   alu_ctrl;
  logic [4:0]    imme;
  logic [RW-1:0] in_rd, out_rd;
  logic          bp_en = 1'b0;

  typedef struct packed {
    logic [63:0] d;
    logic        rw;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  valu_pipe #(.DATA_WIDTH(DW), .MUL_CYCLES(MC), .RD_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .ra(ra), .rb(rb),
    .alu_ctrl(alu_ctrl), .imme(imme), .in_regwrite(in_regwrite), .in_rd(in_rd),
    .out_vld(out_vld), .out_rdy(out_rdy), .alu_out(alu_out), .out_regwrite(out_regwrite),
    .out_rd(out_rd), .busy(busy)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference model, MSB-first lanes; returns {valid, result}.
  function automatic logic [64:0] model(input logic [5:0] f, input logic [1:0] ww,
                                        input logic [63:0] a, input logic [63:0] b,
                                        input logic [4:0] imm);
    int L, n, pos, j, sr, si;
    logic [63:0] mask, la, lb, r, res;
    logic ok;
    L = 8 << ww;
    n = 64 / L;
    mask = (L == 64) ? '1 : ((64'd1 << L) - 64'd1);
    ok = (f <= 6'h0F);
`ifdef VALU_SAT_EN
    if (f == 6'h10 || f == 6'h11) ok = 1'b1;
`endif
    if ((f == 6'h07 || f == 6'h08) && ww == 2'b11) ok = 1'b0;
    res = '0;
    if (ok && (f == 6'h07 || f == 6'h08)) begin
      for (int p = 0; p < n / 2; p++) begin
        j = 2 * p + ((f == 6'h08) ? 1 : 0);
        la = (a >> (64 - (j + 1) * L)) & mask;
        lb = (b >> (64 - (j + 1) * L)) & mask;
        res = res | ((la * lb) << (64 - (p + 1) * 2 * L));
      end
    end else if (ok) begin
      for (int k = 0; k < n; k++) begin
        pos = 64 - (k + 1) * L;
        la = (a >> pos) & mask;
        lb = (b >> pos) & mask;
        sr = int'(lb % L);
        si = int'(imm) % L;
        case (f)
          6'h00: r = la & lb;
          6'h01: r = la | lb;
          6'h02: r = la ^ lb;
          6'h03: r = ~la;
          6'h04: r = la;
          6'h05: r = la + lb;
          6'h06: r = la - lb;
          6'h09: r = (la << (L / 2)) | (la >> (L / 2));
          6'h0A: r = la << sr;
          6'h0B: r = la << si;
          6'h0C: r = la >> sr;
          6'h0D: r = la >> si;
          6'h0E: begin r = la >> sr; if (la[L-1]) r = r | (mask & ~(mask >> sr)); end
          6'h0F: begin r = la >> si; if (la[L-1]) r = r | (mask & ~(mask >> si)); end
          6'h10: begin
            r = la + lb;
            if ((L == 64) ? (r < la) : (r > mask)) r = mask;
          end
          6'h11: r = (lb > la) ? 64'd0 : la - lb;
          default: r = '0;
        endcase
        res = res | ((r & mask) << pos);
      end
    end
    return {ok, res};
  endfunction

  // Called right after a rising edge; returns right after the edge that accepted the op.
  task automatic send(input logic [5:0] f, input logic [1:0] ww, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] imm, input logic rw,
                      input logic [4:0] rd, input logic [63:0] ed, input logic erw,
                      output int waits);
    ra = a; rb = b; imme = imm; in_regwrite = rw; in_rd = rd;
    alu_ctrl = {6'h2A, ww, f};
    in_vld = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_rdy === 1'b1) break;
      waits++;
      if (waits > 60) break;
    end
    if (waits > 60) check("accept_timeout", 72'(in_rdy), 72'(1));
    else sb.push_back(exp_t'{ed, erw, rd});
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic send_m(input logic [5:0] f, input logic [1:0] ww, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] imm, input logic rw,
                        input logic [4:0] rd, output int waits);
    logic [64:0] m;
    m = model(f, ww, a, b, imm);
    send(f, ww, a, b, imm, rw, rd, m[63:0], rw & m[64], waits);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("drain", 72'(sb.size()), 72'(0));
    @(posedge clk); #1;
  endtask

  logic        hold_q = 1'b0;
  logic [70:0] hold_val;
  always @(negedge clk) begin
    exp_t e;
    if (hold_q) check("hold", 72'({out_vld, alu_out, out_regwrite, out_rd}), 72'(hold_val));
    if (rst_n === 1'b1 && out_vld === 1'b1 && out_rdy === 1'b1) begin
      if (sb.size() == 0) check("spurious_out", 72'(out_vld), 72'(0));
      else begin
        e = sb.pop_front();
        check("result", 72'({out_regwrite, out_rd, alu_out}), 72'({e.rw, e.rd, e.d}));
      end
    end
    hold_q   = (rst_n === 1'b1) && (out_vld === 1'b1) && (out_rdy === 1'b0);
    hold_val = {out_vld, alu_out, out_regwrite, out_rd};
  end

  always @(posedge clk) if (bp_en) begin #1; out_rdy = ($urandom_range(0, 3) != 0); end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [64:0] sat_e;
    rst_n = 1'b0; in_vld = 1'b0; ra = '0; rb = '0; alu_ctrl = '0; imme = '0;
    in_regwrite = 1'b0; in_rd = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 72'({in_rdy, busy, out_vld, out_regwrite, out_rd, alu_out}),
          72'({1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0}));
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(6'h05, 2'b00, 64'hFF01_FF01_FF01_FF01, 64'h0101_0101_0101_0101, 5'd0, 1'b1, 5'd3,
         64'h0002_0002_0002_0002, 1'b1, w);
    send(6'h00, 2'b11, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd0, 1'b1, 5'd4,
         64'hF000_F000_F000_F000, 1'b1, w);
    check("b2b_accept", 72'(w), 72'(0));
    send(6'h06, 2'b01, 64'h0000_0005_0010_8000, 64'h0001_0005_0001_0001, 5'd0, 1'b1, 5'd5,
         64'hFFFF_0000_000F_7FFF, 1'b1, w);
    check("b2b_accept2", 72'(w), 72'(0));
    send(6'h09, 2'b10, 64'h1234_5678_9ABC_DEF0, 64'h0, 5'd0, 1'b1, 5'd6,
         64'h5678_1234_DEF0_9ABC, 1'b1, w);
    send(6'h0F, 2'b01, 64'h8000_7FF0_F00F_0010, 64'h0, 5'd4, 1'b1, 5'd7,
         64'hF800_07FF_FF00_0001, 1'b1, w);
    send(6'h0C, 2'b00, 64'h8080_8080_FFFF_FFFF, 64'h0701_0008_0403_0209, 5'd0, 1'b1, 5'd8,
         64'h0140_8080_0F1F_3F7F, 1'b1, w);
    send(6'h0B, 2'b11, 64'h1, 64'h0, 5'd31, 1'b1, 5'd9, 64'h0000_0000_8000_0000, 1'b1, w);
    send(6'h03, 2'b00, 64'h0, 64'h0, 5'd0, 1'b0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
    send(6'h04, 2'b10, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd0, 1'b1, 5'd11,
         64'h0123_4567_89AB_CDEF, 1'b1, w);
    send(6'h12, 2'b00, 64'h1234, 64'h5678, 5'd0, 1'b1, 5'd12, 64'h0, 1'b0, w);
`ifdef VALU_SAT_EN
    sat_e = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
`else
    sat_e = {1'b0, 64'h0};
`endif
    send(6'h10, 2'b00, 64'hF0F0_F0F0_F0F0_F0F0, 64'h2020_2020_2020_2020, 5'd0, 1'b1, 5'd13,
         sat_e[63:0], sat_e[64], w);
`ifdef VALU_SAT_EN
    sat_e = {1'b1, 64'h0000_0007_FFFE_0000};
`else
    sat_e = {1'b0, 64'h0};
`endif
    send(6'h11, 2'b01, 64'h0005_0009_FFFF_0000, 64'h0007_0002_0001_0000, 5'd0, 1'b1, 5'd14,
         sat_e[63:0], sat_e[64], w);

    send(6'h07, 2'b01, 64'hFFFF_1111_0010_2222, 64'h0002_3333_0010_4444, 5'd0, 1'b1, 5'd15,
         64'h0001_FFFE_0000_0100, 1'b1, w);
    for (int k = 0; k <= MC; k++) begin
      @(negedge clk);
      check("mul_stall", 72'({in_rdy, out_vld}), 72'(0));
    end
    @(negedge clk);
    check("mul_latency", 72'(out_vld), 72'(1));
    @(posedge clk); #1;
    send(6'h08, 2'b00, 64'h0003_00FF_0002_0010, 64'h0005_00FF_0080_0010, 5'd0, 1'b1, 5'd16,
         64'h000F_FE01_0100_0100, 1'b1, w);
    send(6'h08, 2'b10, 64'h0000_0001_FFFF_FFFF, 64'h0000_0007_FFFF_FFFF, 5'd0, 1'b0, 5'd17,
         64'hFFFF_FFFE_0000_0001, 1'b0, w);
    drain();
    send(6'h08, 2'b11, 64'h5, 64'h7, 5'd0, 1'b1, 5'd18, 64'h0, 1'b0, w);
    @(negedge clk);
    check("inv_mul_lat", 72'(out_vld), 72'(1));
    @(posedge clk); #1;
    drain();

    out_rdy = 1'b0;
    send(6'h0A, 2'b10, 64'h0000_0001_0000_0001, 64'h0000_001F_0000_001F, 5'd0, 1'b1, 5'd19,
         64'h8000_0000_8000_0000, 1'b1, w);
    repeat (4) begin
      @(negedge clk);
      check("bp_hold", 72'({out_vld, in_rdy, alu_out}), 72'({1'b1, 1'b0, 64'h8000_0000_8000_0000}));
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    send_m(6'h01, 2'b01, 64'h1234_0000_FFFF_0F0F, 64'h0000_4321_0000_F0F0, 5'd0, 1'b1, 5'd20, w);
    check("bp_release_accept", 72'(w), 72'(0));
    drain();

    send_m(6'h07, 2'b00, 64'h1122_3344_5566_7788, 64'h8877_6655_4433_2211, 5'd0, 1'b1, 5'd21, w);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_abort", 72'({out_vld, busy}), 72'(0));
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release", 72'({in_rdy, busy, out_vld}), 72'(3'b100));
    @(posedge clk); #1;

    bp_en = 1'b1;
    for (int t = 0; t < 60; t++) begin
      send_m(6'($urandom_range(0, 18)), 2'($urandom_range(0, 3)), {$urandom, $urandom},
             {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), w);
    end
    bp_en = 1'b0;
    @(posedge clk); #2;
    out_rdy = 1'b1;
    drain();
    @(negedge clk);
    check("idle_end", 72'({busy, out_vld}), 72'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
